rom_loader: RTL and testbench

// - Upstream of the game core's SDRAM port: turns the HPS ioctl byte stream (ROM download, index 0) into
//   32-bit little-endian word writes to the SDRAM controller over its req/ack interface.
// - A 4-deep word FIFO decouples the byte rate from SDRAM ack latency; signals busy/done to gate core reset.

---
 rtl/tecmo_pkg.sv | 19 +
 rtl/rom_loader_if.sv | 14 +
 rtl/loader_fifo.sv | 52 +++++
 rtl/rom_loader.sv | 186 ++++++++++++++++++
 tb/tb_rom_loader.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tecmo_pkg.sv
// Shared types for the ROM download path: loader FSM states and the SDRAM word-write record.
package tecmo_pkg;

  localparam int unsigned SDRAM_ADDR_W = 23;
  localparam int unsigned SDRAM_DATA_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StLoading,
    StFlush,
    StDone
  } loader_state_t;

  typedef struct packed {
    logic [SDRAM_ADDR_W-1:0] addr;
    logic [SDRAM_DATA_W-1:0] data;
  } sdram_word_t;

endpackage

// File: rtl/rom_loader_if.sv
// SDRAM write-request bus: the loader is the master, the SDRAM controller the slave.
interface rom_loader_if;
  import tecmo_pkg::*;

  logic [SDRAM_ADDR_W-1:0] addr;
  logic [SDRAM_DATA_W-1:0] data;
  logic                    we;
  logic                    req;
  logic                    ack;

  modport master (output addr, output data, output we, output req, input ack);
  modport slave  (input addr, input data, input we, input req, output ack);

endinterface

// File: rtl/loader_fifo.sv
// Synchronous FIFO; a pop on a full FIFO frees the slot for a push in the same cycle.
module loader_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [Width-1:0]       wdata,
  input  logic                   pop,
  output logic [Width-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rom_loader.sv
// Packs the ioctl ROM byte stream into 32-bit little-endian SDRAM word writes via a word FIFO.
// Define ROM_LOADER_CHECKSUM_EN to enable the running byte checksum; otherwise checksum reads 0.
module rom_loader
  import tecmo_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH = 20,
  parameter logic [SDRAM_ADDR_W-1:0] BASE_ADDR  = 23'h0,
  parameter logic [7:0]              PAD_BYTE   = 8'h00,
  parameter int unsigned             FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ioctl_download,
  input  logic                  ioctl_wr,
  input  logic [ADDR_WIDTH-1:0] ioctl_addr,
  input  logic [7:0]            ioctl_data,
  rom_loader_if.master          sdram,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [15:0]           checksum
);

  localparam int unsigned IdxW = ADDR_WIDTH - 2;

  loader_state_t   state_q, state_d;
  logic            dl_q;
  logic [31:0]     word_q, word_d, new_word;
  logic [3:0]      mask_q, mask_d, new_mask;
  logic [IdxW-1:0] idx_q, idx_d, wr_idx;
  logic [1:0]      wr_lane;
  logic            pend_q, pend_d;
  logic            overflow_q, overflow_d;
  logic            req_q, req_d;
  logic            dl_rise, start, wr_ok, fresh;

  logic                         push, pop, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  sdram_word_t                  push_word, head;

  function automatic logic [SDRAM_ADDR_W-1:0] word_addr(logic [IdxW-1:0] idx);
    return BASE_ADDR + SDRAM_ADDR_W'(idx);
  endfunction

  assign dl_rise = ioctl_download & ~dl_q;
  assign start   = dl_rise & ((state_q == StIdle) | (state_q == StDone));
  assign wr_ok   = ioctl_wr & (state_q == StLoading);
  assign wr_idx  = ioctl_addr[ADDR_WIDTH-1:2];
  assign wr_lane = ioctl_addr[1:0];
  // pend_q means the assembler holds a finished word, so the incoming byte starts afresh
  assign fresh   = pend_q | (mask_q == '0) | (wr_idx != idx_q);
  assign pop     = req_q & sdram.ack;

  always_comb begin
    new_word = fresh ? {4{PAD_BYTE}} : word_q;
    new_word[{wr_lane, 3'b000} +: 8] = ioctl_data;
    new_mask = (fresh ? 4'b0000 : mask_q) | (4'b0001 << wr_lane);
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    pend_d    = 1'b0;
    push      = 1'b0;
    push_word = '0;

    unique case (state_q)
      StIdle, StDone: if (dl_rise) state_d = StLoading;
      StLoading:      if (!ioctl_download) state_d = StFlush;
      StFlush: begin
        if (mask_q == '0 && !pend_q && fifo_empty && !req_q) state_d = StDone;
      end
      default:        state_d = StIdle;
    endcase

    if (pend_q) begin
      push           = 1'b1;
      push_word.addr = word_addr(idx_q);
      push_word.data = word_q;
      mask_d         = '0;
    end

    if (wr_ok) begin
      if (!pend_q && mask_q != '0 && wr_idx != idx_q) begin
        push           = 1'b1;
        push_word.addr = word_addr(idx_q);
        push_word.data = word_q;
      end
      word_d = new_word;
      mask_d = new_mask;
      idx_d  = wr_idx;
      if (wr_lane == 2'd3) begin
        // A jump onto lane 3 completes two words at once; the second goes out next cycle
        if (push) begin
          pend_d = 1'b1;
        end else begin
          push           = 1'b1;
          push_word.addr = word_addr(wr_idx);
          push_word.data = new_word;
          mask_d         = '0;
        end
      end
    end else if (state_q == StFlush && !pend_q && mask_q != '0) begin
      push           = 1'b1;
      push_word.addr = word_addr(idx_q);
      push_word.data = word_q;
      mask_d         = '0;
    end

    if (start) begin
      mask_d = '0;
      pend_d = 1'b0;
    end

    overflow_d = start ? 1'b0 : (overflow_q | (push & fifo_full & ~pop));
    req_d      = req_q ? (~sdram.ack | (fifo_count > 1) | push) : ~fifo_empty;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      dl_q       <= 1'b0;
      word_q     <= '0;
      mask_q     <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      overflow_q <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dl_q       <= ioctl_download;
      word_q     <= word_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      overflow_q <= overflow_d;
      req_q      <= req_d;
    end
  end

  loader_fifo #(
    .Width ($bits(sdram_word_t)),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The head entry stays in the FIFO until acked, so it is stable for the whole request
  assign sdram.req  = req_q;
  assign sdram.we   = req_q;
  assign sdram.addr = req_q ? head.addr : '0;
  assign sdram.data = req_q ? head.data : '0;

  assign busy     = (state_q == StLoading) | (state_q == StFlush);
  assign done     = (state_q == StDone);
  assign overflow = overflow_q;

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else if (start) begin
      sum_q <= '0;
    end else if (wr_ok) begin
      sum_q <= sum_q + 16'(ioctl_data);
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = 16'h0;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Randomised scoreboard bench for rom_loader: a byte-level model predicts SDRAM word writes.
module tb_rom_loader;
  import tecmo_pkg::*;

  localparam int unsigned AW    = 20;
  localparam logic [22:0] BASE  = 23'h100;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [7:0]    ioctl_data = '0;
  logic          busy, done, overflow;
  logic [15:0]   checksum;

  rom_loader_if sd ();

  rom_loader #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE),
    .PAD_BYTE   (8'h00),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .sdram          (sd),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .checksum       (checksum)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endfunction

  // ---------------- reference model ----------------
  sdram_word_t exp_q[$];
  byte unsigned m_b[4];
  bit           m_v[4];
  int unsigned  m_idx;
  bit           m_ovf;
  logic [15:0]  m_sum;
  bit           hold_ack = 1'b0;

  function automatic void m_clear();
    for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
  endfunction

  function automatic bit m_any();
    return m_v[0] | m_v[1] | m_v[2] | m_v[3];
  endfunction

  function automatic void m_emit();
    sdram_word_t w;
    if (!m_any()) return;
    w.addr = BASE + 23'(m_idx);
    for (int i = 0; i < 4; i++) w.data[8*i +: 8] = m_v[i] ? m_b[i] : 8'h00;
    // With acks held off the queue length is exactly the FIFO occupancy
    if (hold_ack && exp_q.size() >= DEPTH) m_ovf = 1'b1;
    else exp_q.push_back(w);
    m_clear();
  endfunction

  function automatic void m_byte(int unsigned a, byte unsigned d);
    int unsigned am   = a % (1 << AW);
    int unsigned idx  = am / 4;
    int unsigned lane = am % 4;
    if (m_any() && idx != m_idx) m_emit();
    m_idx = idx;
    m_b[lane] = d;
    m_v[lane] = 1'b1;
    m_sum += 16'(d);
    if (lane == 3) m_emit();
  endfunction

  function automatic logic [15:0] exp_sum();
`ifdef ROM_LOADER_CHECKSUM_EN
    return m_sum;
`else
    return 16'h0;
`endif
  endfunction

  // ---------------- SDRAM responder and monitor ----------------
  sdram_word_t mon_e;
  bit          prev_held = 1'b0;
  logic [22:0] prev_addr;
  logic [31:0] prev_data;
  int          wait_cnt = 0;

  initial begin
    sd.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_held && sd.req) begin
        chk("stable_addr", sd.addr, prev_addr);
        chk("stable_data", sd.data, prev_data);
      end
      sd.ack = 1'b0;
      if (!reset && sd.req && !hold_ack && ($urandom_range(0, 2) != 0 || wait_cnt >= 2)) begin
        sd.ack   = 1'b1;
        wait_cnt = 0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h, want no write", sd.addr, sd.data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_addr", sd.addr, mon_e.addr);
          chk("write_data", sd.data, mon_e.data);
          chk("write_we", sd.we, 1'b1);
        end
      end else if (!sd.req && $urandom_range(0, 7) == 0) begin
        sd.ack = 1'b1;  // stray ack, must be ignored
      end else if (sd.req) begin
        wait_cnt++;
      end
      prev_held = !reset && sd.req && !sd.ack;
      prev_addr = sd.addr;
      prev_data = sd.data;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic start_dl();
    @(negedge clk);
    ioctl_download = 1'b1;
    m_clear();
    m_ovf = 1'b0;
    m_sum = '0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_loading", busy, 1'b1);
    chk("done_loading", done, 1'b0);
  endtask

  task automatic send(int unsigned a, byte unsigned d, int unsigned gap);
    @(negedge clk);
    ioctl_wr   = 1'b1;
    ioctl_addr = AW'(a);
    ioctl_data = d;
    m_byte(a, d);
    @(negedge clk);
    ioctl_wr = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic end_dl();
    int k;
    @(negedge clk);
    ioctl_download = 1'b0;
    m_emit();
    k = 0;
    while (!done && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("done_reached", done, 1'b1);
    chk("busy_done", busy, 1'b0);
    chk("overflow", overflow, m_ovf);
    chk("checksum", checksum, exp_sum());
    chk("writes_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a;
    int unsigned p;
    m_clear();
    m_sum = '0;
    m_ovf = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req", sd.req, 1'b0);
    chk("rst_we", sd.we, 1'b0);
    chk("rst_addr", sd.addr, 0);
    chk("rst_data", sd.data, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_checksum", checksum, 0);
    reset = 1'b0;

    // One aligned word, with request latency
    start_dl();
    send(0, 8'h11, 0);
    send(1, 8'h22, 0);
    send(2, 8'h33, 0);
    @(negedge clk);
    ioctl_wr = 1'b1; ioctl_addr = AW'(3); ioctl_data = 8'h44; m_byte(3, 8'h44);
    @(negedge clk);
    ioctl_wr = 1'b0;
    chk("req_latency_1", sd.req, 1'b0);
    @(negedge clk);
    chk("req_latency_2", sd.req, 1'b1);
    end_dl();

    // Six bytes from addr 8, partial word flushed at the end
    start_dl();
    for (int i = 0; i < 6; i++) send(8 + i, 8'hAA + 8'(i * 17), 0);
    end_dl();

    // Non-sequential jump commits the padded partial word first
    start_dl();
    send(0, 8'h5A, 1);
    send(1, 8'hC3, 1);
    send(12, 8'h7E, 1);
    end_dl();

    // Acks held off: FIFO fills, later words dropped, overflow sticks
    hold_ack = 1'b1;
    start_dl();
    for (int i = 0; i < 24; i++) send(64 + i, 8'($urandom), 0);
    @(negedge clk);
    chk("overflow_set", overflow, 1'b1);
    chk("req_held", sd.req, 1'b1);
    hold_ack = 1'b0;
    end_dl();

    // Reset with a request pending and words queued
    hold_ack = 1'b1;
    start_dl();
    for (int i = 0; i < 14; i++) send(i, 8'($urandom), 0);
    @(negedge clk);
    chk("pre_reset_req", sd.req, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_reset_req", sd.req, 1'b0);
    chk("mid_reset_busy", busy, 1'b0);
    chk("mid_reset_done", done, 1'b0);
    chk("mid_reset_ovf", overflow, 1'b0);
    exp_q.delete();
    m_clear();
    @(negedge clk);
    ioctl_download = 1'b0;
    reset = 1'b0;
    hold_ack = 1'b0;
    start_dl();
    for (int i = 0; i < 6; i++) send(20 + i, 8'($urandom), 1);
    end_dl();

    // Checksum over bytes 01..FF
    start_dl();
    for (int i = 1; i <= 255; i++) send(i - 1, 8'(i), 1);
    end_dl();
`ifdef ROM_LOADER_CHECKSUM_EN
    chk("checksum_01_ff", checksum, 16'h7F80);
`else
    chk("checksum_01_ff", checksum, 16'h0000);
`endif

    // Random streams: mostly sequential, with jumps and rewrites
    for (int r = 0; r < 3; r++) begin
      start_dl();
      a = (r == 2) ? 32'hFFFF0 : $urandom_range(0, 255);
      for (int i = 0; i < 48; i++) begin
        send(a, 8'($urandom), $urandom_range(2, 3));
        p = $urandom_range(0, 15);
        if (p == 0) a = $urandom_range(0, 1023);
        else if (p != 1) a = a + 1;
      end
      end_dl();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
